fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the program counter register and the instruction-memory fetch port of the rv32i core.
//  Arbitrates trap, branch and sequential PC updates into the pc block's stall/taken/target inputs.
//  Keeps at most one fetch outstanding, discards responses made stale by a redirect, and skid-buffers
//  one instruction while decode stalls.
// PARAMETERS
//  XLEN        32  address/instruction width
//  RESET_HOLD  2   cycles after rst_n release before first imem_req (pc sync reset settles); 0 = none
// PORTS
//  clk            in   1     core clock
//  rst_n          in   1     asynchronous, active-low reset
//  pc_in          in   XLEN  current pc_out of pc block; address of next fetch
//  pc_stall       out  1     to pc.stall; 0 only on cycle a fetch is granted
//  pc_taken       out  1     to pc.taken; redirect this cycle
//  pc_target      out  XLEN  to pc.target
//  stall_id       in   1     decode hazard stall; IF/ID holds
//  br_taken       in   1     EX-stage branch/jump redirect
//  br_target      in   XLEN  EX-stage redirect address
//  trap           in   1     trap/mret redirect; priority over br_taken
//  trap_vec       in   XLEN  trap redirect address
//  imem_req       out  1     fetch request; address = pc_in
//  imem_gnt       in   1     request accepted this cycle
//  imem_rvalid    in   1     response valid (>=1 cycle after grant)
//  imem_rdata     in   XLEN  response instruction
//  if_valid       out  1     if_instr/if_pc valid for IF/ID (captured when !stall_id)
//  if_instr       out  XLEN  fetched instruction
//  if_pc          out  XLEN  address of if_instr
//  flush_if       out  1     kill IF/ID contents
//  flush_id       out  1     kill ID/EX contents
// BEHAVIOUR
//  Async reset: state=S_HOLD, hold cnt=RESET_HOLD, buf_v=0; imem_req=0, pc_stall=1, pc_taken=0, if_valid=0, flushes=0.
//  States: S_HOLD -> S_REQ when cnt==0 (decrement per cycle); S_REQ -> S_WAIT on imem_req&&imem_gnt;
//   S_WAIT -> S_REQ on imem_rvalid; S_DRAIN -> S_REQ on imem_rvalid (response dropped).
//  imem_req = (S_REQ) && !stall_id && !buf_v && !redirect. Grant cycle: pc_stall=0, fetch addr latched as if_pc.
//  redirect = trap | br_taken; pc_target = trap ? trap_vec : br_target; pc_taken=redirect; flush_if=flush_id=redirect.
//  Redirect in S_WAIT without rvalid -> S_DRAIN; with rvalid same cycle -> response dropped, S_REQ.
//  Redirect in S_REQ/S_DRAIN/S_HOLD: state unchanged (S_HOLD count continues). Redirect clears buf_v.
//  rvalid in S_WAIT, no redirect: stall_id=0 -> pass-through (if_valid=1, same cycle); stall_id=1 -> store in buffer.
//  buf_v: if_valid=1 from buffer; cleared on first cycle with stall_id=0. rvalid never coincides with buf_v.
//  Stall never blocks a redirect. rvalid outside S_WAIT/S_DRAIN is ignored. Peak throughput 1 instr / 2 cycles.
//  Reset mid-fetch: outstanding response after release is ignored (state S_HOLD/S_REQ).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: adds outputs misalign_exc(1), misalign_addr(XLEN). br_taken with
//   br_target[1:0]!=0 and no trap: pc_taken=0, flushes asserted, misalign_exc pulses 1 cycle with registered
//   br_target; state transitions as for a redirect. Undefined: pc_target[1:0] forced to 2'b00, no extra ports.
// STRUCTURE
//  fetch_pkg: XLEN, fetch_state_e {S_HOLD,S_REQ,S_WAIT,S_DRAIN}, insn/pc pair struct.
//  Sub-module fetch_skid_buf: one-entry instr+pc buffer (load, consume, clear; buf_v output).
// TESTING
//  Reset release, RESET_HOLD=2, gnt tied 1, rvalid 1 cycle later -> first imem_req on cycle 3; pc_stall=0 only on grant.
//  Steady fetch from 0x0 -> if_pc 0x0,0x4,0x8 with if_valid every 2nd cycle, pc_taken=0.
//  br_taken=1 target 0x100 while S_WAIT -> pc_taken=1, flushes=1, next rvalid dropped, next fetch at 0x100.
//  trap=1 (vec 0x80) and br_taken=1 (0x200) same cycle -> pc_target=0x80.
//  stall_id=1 when rvalid (instr 0x00000013) -> buffered, no imem_req; stall_id=0 -> if_valid=1 with 0x13, then fetch resumes.
//  FETCH_MISALIGN_TRAP_EN, br_target=0x102 -> misalign_exc=1, misalign_addr=0x102, pc_taken=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the rv32i instruction fetch controller
package fetch_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      S_HOLD,
      S_REQ,
      S_WAIT,
      S_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_pair_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory fetch port (request/grant, response valid/data)
interface fetch_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, input imem_gnt, input imem_rvalid, input imem_rdata);
   modport slave  (input imem_req, output imem_gnt, output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction/pc holding buffer used while decode stalls
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        consume,
   input  logic        clear,
   input  fetch_pair_t din,
   output fetch_pair_t dout,
   output logic        buf_v
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_v <= 1'b0;
         dout  <= '0;
      end else begin
         if (clear)
            buf_v <= 1'b0;
         else if (load)
            buf_v <= 1'b1;
         else if (consume)
            buf_v <= 1'b0;
         if (load)
            dout <= din;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - pc sequencing and single-outstanding instruction fetch for the rv32i core
// Optional FETCH_MISALIGN_TRAP_EN: misaligned branch targets raise misalign_exc instead of redirecting.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int RESET_HOLD = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_stall,
   output logic            pc_taken,
   output logic [XLEN-1:0] pc_target,
   input  logic            stall_id,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   fetch_if.master         imem,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            flush_if,
   output logic            flush_id
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign_exc,
   output logic [XLEN-1:0] misalign_addr
`endif
);

   localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;

   fetch_state_e    state, state_nxt;
   logic [CW-1:0]   hold_cnt, cnt_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] tgt;
   logic            redirect, req, grant, pass, load, consume, buf_v;
   fetch_pair_t     buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_HOLD;
         hold_cnt <= CW'(RESET_HOLD);
      end else begin
         state    <= state_nxt;
         hold_cnt <= cnt_nxt;
      end
   end

   // A redirect while a response is outstanding must swallow that response before refetching.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = hold_cnt;
      case (state)
         S_HOLD: begin
            if (hold_cnt == '0)
               state_nxt = S_REQ;
            else
               cnt_nxt = hold_cnt - 1'b1;
         end
         S_REQ: begin
            if (grant)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (redirect)
               state_nxt = imem.imem_rvalid ? S_REQ : S_DRAIN;
            else if (imem.imem_rvalid)
               state_nxt = S_REQ;
         end
         S_DRAIN: begin
            if (imem.imem_rvalid)
               state_nxt = S_REQ;
         end
         default: state_nxt = S_HOLD;
      endcase
   end

   always_comb begin
      redirect = trap | br_taken;
      req      = (state == S_REQ) && !stall_id && !buf_v && !redirect;
      grant    = req && imem.imem_gnt;
      pc_stall = !grant;
      pass     = (state == S_WAIT) && imem.imem_rvalid && !redirect && !stall_id;
      load     = (state == S_WAIT) && imem.imem_rvalid && !redirect && stall_id;
      consume  = buf_v && !stall_id;
      if_valid = !redirect && (pass || buf_v);
      if_instr = buf_v ? buf_q.instr : imem.imem_rdata;
      if_pc    = buf_v ? buf_q.pc : fetch_pc;
      flush_if = redirect;
      flush_id = redirect;
      tgt      = trap ? trap_vec : br_target;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_taken  = redirect && !(br_taken && !trap && (br_target[1:0] != 2'b00));
      pc_target = tgt;
`else
      pc_taken  = redirect;
      pc_target = tgt & ~XLEN'(3);
`endif
   end

   assign imem.imem_req = req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fetch_pc <= '0;
      else if (grant)
         fetch_pc <= pc_in;
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic mis_br;
   assign mis_br = br_taken && !trap && (br_target[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_exc  <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_exc <= mis_br;
         if (mis_br)
            misalign_addr <= br_target;
      end
   end
`endif

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .consume (consume),
      .clear   (redirect),
      .din     ({imem.imem_rdata, fetch_pc}),
      .dout    (buf_q),
      .buf_v   (buf_v)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed-vector bench for fetch_ctrl with pc register and imem models
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc = 32'h0;
   logic        pc_stall, pc_taken, if_valid, flush_if, flush_id;
   logic [31:0] pc_target, if_instr, if_pc;
   logic        stall_id, br_taken, trap;
   logic [31:0] br_target, trap_vec;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_exc;
   logic [31:0] misalign_addr;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   int          lat = 1;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = 32'h0;

   fetch_if imem_bus ();

   fetch_ctrl #(.RESET_HOLD(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_in     (pc),
      .pc_stall  (pc_stall),
      .pc_taken  (pc_taken),
      .pc_target (pc_target),
      .stall_id  (stall_id),
      .br_taken  (br_taken),
      .br_target (br_target),
      .trap      (trap),
      .trap_vec  (trap_vec),
      .imem      (imem_bus),
      .if_valid  (if_valid),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .flush_if  (flush_if),
      .flush_id  (flush_id)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign_exc  (misalign_exc),
      .misalign_addr (misalign_addr)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h80) ? 32'h0000_0013 : (32'hA000_0000 | a);
   endfunction

   // pc register model: redirect wins over sequential advance
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= 32'h0;
      else if (pc_taken)
         pc <= pc_target;
      else if (!pc_stall)
         pc <= pc + 32'h4;
   end

   // memory keeps its pending response across a core reset
   always @(posedge clk) begin
      if (imem_bus.imem_req && imem_bus.imem_gnt) begin
         pend_cnt  <= lat;
         pend_addr <= pc;
      end else if (pend_cnt != 0) begin
         pend_cnt <= pend_cnt - 1;
      end
   end

   assign imem_bus.imem_gnt    = 1'b1;
   assign imem_bus.imem_rvalid = (pend_cnt == 1);
   assign imem_bus.imem_rdata  = mem_word(pend_addr);

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; stall_id = 1'b0; br_taken = 1'b0; trap = 1'b0;
      br_target = 32'h0; trap_vec = 32'h0;
      repeat (2) next_cyc();
      #1;
      check_vec("rst_req",      32'(imem_bus.imem_req), 32'd0);
      check_vec("rst_pc_stall", 32'(pc_stall), 32'd1);
      check_vec("rst_pc_taken", 32'(pc_taken), 32'd0);
      check_vec("rst_if_valid", 32'(if_valid), 32'd0);
      check_vec("rst_flush_if", 32'(flush_if), 32'd0);
      check_vec("rst_flush_id", 32'(flush_id), 32'd0);

      next_cyc(); rst_n = 1'b1; #1;
      check_vec("hold_c0_req", 32'(imem_bus.imem_req), 32'd0);
      for (int c = 1; c <= 2; c++) begin
         next_cyc(); #1;
         check_vec("hold_req", 32'(imem_bus.imem_req), 32'd0);
         check_vec("hold_pc_stall", 32'(pc_stall), 32'd1);
      end
      next_cyc(); #1;
      check_vec("c3_req", 32'(imem_bus.imem_req), 32'd1);
      check_vec("c3_pc_stall", 32'(pc_stall), 32'd0);

      next_cyc(); #1;
      check_vec("c4_if_valid", 32'(if_valid), 32'd1);
      check_vec("c4_if_pc", if_pc, 32'h0);
      check_vec("c4_if_instr", if_instr, 32'hA000_0000);
      check_vec("c4_req", 32'(imem_bus.imem_req), 32'd0);
      check_vec("c4_pc_stall", 32'(pc_stall), 32'd1);
      next_cyc(); #1;
      check_vec("c5_if_valid", 32'(if_valid), 32'd0);
      check_vec("c5_req", 32'(imem_bus.imem_req), 32'd1);
      next_cyc(); #1;
      check_vec("c6_if_valid", 32'(if_valid), 32'd1);
      check_vec("c6_if_pc", if_pc, 32'h4);
      check_vec("c6_pc_taken", 32'(pc_taken), 32'd0);
      next_cyc(); #1;
      check_vec("c7_req", 32'(imem_bus.imem_req), 32'd1);
      next_cyc(); #1;
      check_vec("c8_if_valid", 32'(if_valid), 32'd1);
      check_vec("c8_if_pc", if_pc, 32'h8);
      check_vec("c8_if_instr", if_instr, 32'hA000_0008);

      next_cyc(); lat = 2; #1;
      check_vec("c9_req", 32'(imem_bus.imem_req), 32'd1);
      next_cyc(); br_taken = 1'b1; br_target = 32'h100; #1;
      check_vec("br_pc_taken", 32'(pc_taken), 32'd1);
      check_vec("br_pc_target", pc_target, 32'h100);
      check_vec("br_flush_if", 32'(flush_if), 32'd1);
      check_vec("br_flush_id", 32'(flush_id), 32'd1);
      check_vec("br_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); br_taken = 1'b0; lat = 1; #1;
      check_vec("drain_rvalid", 32'(imem_bus.imem_rvalid), 32'd1);
      check_vec("drain_if_valid", 32'(if_valid), 32'd0);
      check_vec("drain_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); #1;
      check_vec("c12_req", 32'(imem_bus.imem_req), 32'd1);
      next_cyc(); #1;
      check_vec("c13_if_valid", 32'(if_valid), 32'd1);
      check_vec("c13_if_pc", if_pc, 32'h100);
      check_vec("c13_if_instr", if_instr, 32'hA000_0100);

      next_cyc();
      trap = 1'b1; trap_vec = 32'h80; br_taken = 1'b1; br_target = 32'h200; #1;
      check_vec("trap_pc_target", pc_target, 32'h80);
      check_vec("trap_pc_taken", 32'(pc_taken), 32'd1);
      check_vec("trap_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); trap = 1'b0; br_taken = 1'b0; #1;
      check_vec("c15_req", 32'(imem_bus.imem_req), 32'd1);

      next_cyc(); stall_id = 1'b1; #1;
      check_vec("stall_if_valid", 32'(if_valid), 32'd0);
      check_vec("stall_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); #1;
      check_vec("buf_req", 32'(imem_bus.imem_req), 32'd0);
      check_vec("buf_if_valid", 32'(if_valid), 32'd1);
      check_vec("buf_if_instr", if_instr, 32'h13);
      next_cyc(); stall_id = 1'b0; #1;
      check_vec("unstall_if_valid", 32'(if_valid), 32'd1);
      check_vec("unstall_if_instr", if_instr, 32'h13);
      check_vec("unstall_if_pc", if_pc, 32'h80);
      check_vec("unstall_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); #1;
      check_vec("resume_req", 32'(imem_bus.imem_req), 32'd1);
      next_cyc(); #1;
      check_vec("resume_if_valid", 32'(if_valid), 32'd1);
      check_vec("resume_if_pc", if_pc, 32'h84);

      next_cyc(); br_taken = 1'b1; br_target = 32'h102; #1;
      check_vec("mis_flush_if", 32'(flush_if), 32'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
      check_vec("mis_pc_taken", 32'(pc_taken), 32'd0);
`else
      check_vec("mis_pc_taken", 32'(pc_taken), 32'd1);
      check_vec("mis_pc_target", pc_target, 32'h100);
`endif
      next_cyc(); br_taken = 1'b0; lat = 2; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      check_vec("mis_exc", 32'(misalign_exc), 32'd1);
      check_vec("mis_addr", misalign_addr, 32'h102);
`endif
      check_vec("c22_req", 32'(imem_bus.imem_req), 32'd1);

      next_cyc(); rst_n = 1'b0; #1; rst_n = 1'b1; #1;
      check_vec("midrst_req", 32'(imem_bus.imem_req), 32'd0);
      check_vec("midrst_pc_stall", 32'(pc_stall), 32'd1);
      next_cyc(); #1;
      check_vec("stale_rvalid", 32'(imem_bus.imem_rvalid), 32'd1);
      check_vec("stale_if_valid", 32'(if_valid), 32'd0);
      check_vec("stale_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); #1;
      check_vec("c25_req", 32'(imem_bus.imem_req), 32'd0);
      next_cyc(); #1;
      check_vec("c26_req", 32'(imem_bus.imem_req), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
